pipe_wb: RTL and testbench

- Write-back stage directly downstream of the memory-access stage. Consumes its result triple {wb_e, wb_idx, wb_out}.
- Buffers results in a small in-order FIFO and commits each to the register-file write port.
- Provides a youngest-match forwarding lookup over all pending (uncommitted) results so the decode and execute stages never read stale operands.
- Fully synchronous. It replaces the edge-triggered ack style with a valid/ready handshake.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fwd_match.sv | 33 +++
 rtl/pipe_wb.sv | 135 +++++++++++++
 tb/tb_pipe_wb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back stage: result entry layout and default widths.
package wb_pkg;

    localparam int IDX_L  = 5;
    localparam int DATA_L = 32;

    typedef struct packed {
        logic              wb_e;
        logic [IDX_L-1:0]  idx;
        logic [DATA_L-1:0] val;
    } wb_entry_t;

    // Occupancy states of the write-back FIFO.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PART  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first forwarding search over the pending write-back entries.
// Entries just below wr_ptr are the most recent, so the scan walks backwards from there.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [IDX_L-1:0]  query,
    output logic              hit,
    output logic [DATA_L-1:0] val
);

    logic [PTR_W-1:0] slot;

    always_comb begin
        hit  = 1'b0;
        val  = '0;
        slot = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            slot = wr_ptr - PTR_W'(k);
            if (!hit && (query != '0) && valid[slot] &&
                entries[slot].wb_e && (entries[slot].idx == query)) begin
                hit = 1'b1;
                val = entries[slot].val;
            end
        end
    end

endmodule

// File: rtl/pipe_wb.sv
// Write-back stage: in-order result FIFO committing to the register file with forwarding lookup.
// Optional feature macro WB_RETIRE_CNT_EN implements retire_cnt; otherwise it is tied to 0.
module pipe_wb #(
    parameter int DEPTH  = 2,
    parameter int DATA_L = wb_pkg::DATA_L,
    parameter int IDX_L  = wb_pkg::IDX_L
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_e,
    input  logic [IDX_L-1:0]  in_wb_idx,
    input  logic [DATA_L-1:0] in_wb_val,
    input  logic              rf_busy,
    output logic              rf_we,
    output logic [IDX_L-1:0]  rf_widx,
    output logic [DATA_L-1:0] rf_wdata,
    input  logic [IDX_L-1:0]  fwd_q_idx,
    output logic              fwd_hit,
    output logic [DATA_L-1:0] fwd_val,
    output logic [31:0]       retire_cnt
);
    import wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    wb_entry_t        head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [DEPTH-1:0] valid_mask;
    logic [PTR_W-1:0] offset;

    assign not_empty = (count != '0);
    assign in_ready  = (count != (PTR_W+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && !rf_busy;
    assign head      = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = ST_PART;
        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next == (PTR_W+1)'(DEPTH)) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= ST_EMPTY;
        end else begin
            count <= count_next;
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: every consumer is qualified by count or the valid mask.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{wb_e: in_wb_e, idx: in_wb_idx, val: in_wb_val};
        end
    end

    always_comb begin
        rf_we    = not_empty && head.wb_e && (head.idx != '0) && !rf_busy;
        rf_widx  = not_empty ? head.idx : '0;
        rf_wdata = not_empty ? head.val : '0;
    end

    // A slot is pending when its distance from rd_ptr is below the occupancy.
    always_comb begin
        valid_mask = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - rd_ptr;
            valid_mask[i] = ({1'b0, offset} < count);
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries (mem),
        .valid   (valid_mask),
        .wr_ptr  (wr_ptr),
        .query   (fwd_q_idx),
        .hit     (fwd_hit),
        .val     (fwd_val)
    );

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (pop) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_wb.sv
// Directed self-checking bench for pipe_wb (DEPTH=2): commit, busy fill, forwarding, reset, counter wrap.
module tb_pipe_wb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_e;
    logic [4:0]  in_wb_idx;
    logic [31:0] in_wb_val;
    logic        rf_busy;
    logic        rf_we;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_q_idx;
    logic        fwd_hit;
    logic [31:0] fwd_val;
    logic [31:0] retire_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] ret_exp = 0;

    pipe_wb #(.DEPTH(2), .DATA_L(32), .IDX_L(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wb_e    (in_wb_e),
        .in_wb_idx  (in_wb_idx),
        .in_wb_val  (in_wb_val),
        .rf_busy    (rf_busy),
        .rf_we      (rf_we),
        .rf_widx    (rf_widx),
        .rf_wdata   (rf_wdata),
        .fwd_q_idx  (fwd_q_idx),
        .fwd_hit    (fwd_hit),
        .fwd_val    (fwd_val),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ret_model(input logic [31:0] n);
`ifdef WB_RETIRE_CNT_EN
        return n;
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_wb_e = 0; in_wb_idx = 0; in_wb_val = 0;
        rf_busy = 0; fwd_q_idx = 0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
        checks++; if (rf_widx !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rf_data got %0d/%h want 0/0", rf_widx, rf_wdata); end
        checks++; if (fwd_hit !== 1'b0 || fwd_val !== 32'd0) begin errors++; $display("[TB] FAIL reset_fwd got %b/%h want 0/0", fwd_hit, fwd_val); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_retire got %0d want 0", retire_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic_commit();
        @(negedge clk);
        in_valid = 1; in_wb_e = 1; in_wb_idx = 5; in_wb_val = 32'h1234; fwd_q_idx = 5;
        @(negedge clk);
        in_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("[TB] FAIL basic_we got %b want 1", rf_we); end
        checks++; if (rf_widx !== 5'd5 || rf_wdata !== 32'h1234) begin errors++; $display("[TB] FAIL basic_data got %0d/%h want 5/1234", rf_widx, rf_wdata); end
        checks++; if (fwd_hit !== 1'b1 || fwd_val !== 32'h1234) begin errors++; $display("[TB] FAIL basic_fwd_popping got %b/%h want 1/1234", fwd_hit, fwd_val); end
        ret_exp++;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || rf_widx !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL basic_drained got %b/%0d/%h want 0/0/0", rf_we, rf_widx, rf_wdata); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("[TB] FAIL basic_fwd_gone got %b want 0", fwd_hit); end
        checks++; if (retire_cnt !== ret_model(ret_exp)) begin errors++; $display("[TB] FAIL basic_retire got %0d want %0d", retire_cnt, ret_model(ret_exp)); end
    endtask

    task automatic test_no_write();
        @(negedge clk);
        in_valid = 1; in_wb_e = 1; in_wb_idx = 0; in_wb_val = 32'hFFFF; fwd_q_idx = 0;
        @(negedge clk);
        in_wb_e = 0; in_wb_idx = 3; in_wb_val = 32'h55;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL idx0_we got %b want 0", rf_we); end
        checks++; if (rf_wdata !== 32'hFFFF) begin errors++; $display("[TB] FAIL idx0_data got %h want ffff", rf_wdata); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("[TB] FAIL idx0_fwd got %b want 0", fwd_hit); end
        ret_exp++;
        @(negedge clk);
        in_valid = 0; fwd_q_idx = 3;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_widx !== 5'd3) begin errors++; $display("[TB] FAIL nowb_head got %b/%0d want 0/3", rf_we, rf_widx); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("[TB] FAIL nowb_fwd got %b want 0", fwd_hit); end
        checks++; if (retire_cnt !== ret_model(ret_exp)) begin errors++; $display("[TB] FAIL idx0_retire got %0d want %0d", retire_cnt, ret_model(ret_exp)); end
        ret_exp++;
        @(negedge clk);
        checks++; if (retire_cnt !== ret_model(ret_exp) || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nowb_retire got %0d/%b want %0d/1", retire_cnt, in_ready, ret_model(ret_exp)); end
    endtask

    task automatic test_busy_fill();
        @(negedge clk);
        rf_busy = 1; in_valid = 1; in_wb_e = 1; in_wb_idx = 1; in_wb_val = 32'h11;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || rf_widx !== 5'd1) begin errors++; $display("[TB] FAIL busy_one got %b/%b/%0d want 1/0/1", in_ready, rf_we, rf_widx); end
        in_wb_idx = 2; in_wb_val = 32'h22;
        @(negedge clk);
        in_wb_idx = 3; in_wb_val = 32'h33;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_full_ready got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || rf_widx !== 5'd1 || rf_wdata !== 32'h11) begin errors++; $display("[TB] FAIL busy_hold got %b/%0d/%h want 0/1/11", in_ready, rf_widx, rf_wdata); end
        rf_busy = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 5'd1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL commit_a got %b/%0d/%b want 1/1/0", rf_we, rf_widx, in_ready); end
        ret_exp++;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_widx !== 5'd2 || rf_wdata !== 32'h22) begin errors++; $display("[TB] FAIL commit_b got %b/%0d/%h want 1/2/22", rf_we, rf_widx, rf_wdata); end
        ret_exp++;
        @(negedge clk);
        in_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 5'd3 || rf_wdata !== 32'h33) begin errors++; $display("[TB] FAIL commit_c got %b/%0d/%h want 1/3/33", rf_we, rf_widx, rf_wdata); end
        ret_exp++;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || retire_cnt !== ret_model(ret_exp)) begin errors++; $display("[TB] FAIL busy_drain got %b/%0d want 0/%0d", rf_we, retire_cnt, ret_model(ret_exp)); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        rf_busy = 1; in_valid = 1; in_wb_e = 1; in_wb_idx = 7; in_wb_val = 32'hA;
        @(negedge clk);
        in_wb_val = 32'hB;
        @(negedge clk);
        in_valid = 0; fwd_q_idx = 7;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_val !== 32'hB) begin errors++; $display("[TB] FAIL fwd_youngest got %b/%h want 1/b", fwd_hit, fwd_val); end
        fwd_q_idx = 0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_val !== 32'd0) begin errors++; $display("[TB] FAIL fwd_q0 got %b/%h want 0/0", fwd_hit, fwd_val); end
        fwd_q_idx = 9;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_val !== 32'd0) begin errors++; $display("[TB] FAIL fwd_miss got %b/%h want 0/0", fwd_hit, fwd_val); end
    endtask

    task automatic test_reset_full();
        fwd_q_idx = 7;
        @(negedge clk);
        rst = 1; rf_busy = 0;
        #1;
        checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || fwd_hit !== 1'b0) begin errors++; $display("[TB] FAIL rst_full got %b/%b/%b want 1/0/0", in_ready, rf_we, fwd_hit); end
        ret_exp = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rf_we !== 1'b0 || retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL rst_no_write cyc%0d got %b/%0d want 0/0", i, rf_we, retire_cnt); end
        end
    endtask

    task automatic test_retire_wrap();
        @(negedge clk);
`ifdef WB_RETIRE_CNT_EN
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
`endif
        in_valid = 1; in_wb_e = 1; in_wb_idx = 4; in_wb_val = 32'h44;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL retire_wrap got %h want 0", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_no_write();
        test_busy_fill();
        test_forward();
        test_reset_full();
        test_retire_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
